// File: rtl/sr_fetch_queue_pkg.sv
// Shared types and constants for the sr_cpu instruction fetch queue.
package sr_fetch_queue_pkg;

    // Canonical NOP (addi x0, x0, 0) shown to the core when nothing is queued.
    localparam logic [31:0] RVIN_NOP       = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // One queued instruction with the byte PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Identity of the single ROM read in flight; epoch filters stale returns.
    typedef struct packed {
        logic        epoch;
        logic [31:0] pc;
    } inflight_tag_t;

endpackage

// File: rtl/sr_fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries with flush.
// Push and pop may coincide at full or empty; flush wins over both.
module sr_fetch_fifo
    import sr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    // A pop frees the slot a same-cycle push may take, so full+pop+push is legal.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        full    = (count == (PW + 1)'(DEPTH));
        empty   = (count == '0);
        head    = mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: only slots below count are ever shown.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sr_fetch_queue.sv
// Fetch stage: issues word reads to a 1-cycle synchronous ROM, queues the
// returned words with their PC, and hands them to the core with valid/ready.
// Redirects flush the queue and bump an epoch so late ROM returns are dropped.
module sr_fetch_queue
    import sr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] im_addr,
    output logic        im_req,
    input  logic [31:0] im_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [29:0]    fetch_word;     // fetch PC held as a word address, wraps mod 2^32 bytes
    logic           epoch;
    logic           inflight;
    inflight_tag_t  tag;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    fetch_entry_t   head;
    fetch_entry_t   push_data;
    logic           push;
    logic           pop;
    logic [CW:0]    occupancy;
    logic [1:0]     redirect_pc_unused;

    // Byte offset of a redirect target is ignored; fetch is word aligned.
    assign redirect_pc_unused = redirect_pc[1:0];

    // Credit check counts the outstanding read so a return can never hit a full queue.
    always_comb begin
        occupancy = {1'b0, count} + (CW + 1)'(inflight);
        im_req    = !rst && !redirect && !full && (occupancy < (CW + 1)'(DEPTH));
        im_addr   = fetch_word;
        push      = inflight && (tag.epoch == epoch) && !redirect;
        push_data = '{pc: tag.pc, instr: im_data};
        pop       = out_ready && !empty && !redirect;
        out_valid = !empty;
        instr     = out_valid ? head.instr : RVIN_NOP;
        instr_pc  = out_valid ? head.pc    : 32'h0;
    end

    // Fetch PC, epoch and in-flight tag; a redirect overrides the sequential increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_word <= RESET_PC[31:2];
            epoch      <= 1'b0;
            inflight   <= 1'b0;
            tag        <= '0;
        end else begin
            inflight <= im_req;
            if (im_req) tag <= '{epoch: epoch, pc: {fetch_word, 2'b00}};
            if (redirect) begin
                fetch_word <= redirect_pc[31:2];
                epoch      <= ~epoch;
            end else if (im_req) begin
                fetch_word <= fetch_word + 30'd1;
            end
        end
    end

    sr_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_sr_fetch_queue.sv
// Directed bench for sr_fetch_queue. The ROM returns its own word address,
// so the expected instruction for byte PC p is p >> 2.
module tb_sr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] im_addr;
    logic        im_req;
    logic [31:0] im_data = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        out_valid;
    logic        out_ready;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;

    sr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .im_addr     (im_addr),
        .im_req      (im_req),
        .im_data     (im_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM, one cycle latency.
    always @(posedge clk) if (im_req) im_data <= {2'b00, im_addr};

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect = 1'b1; redirect_pc = pc;
        step();
        redirect = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; out_ready = 1'b1;
        step(); step();
        redirect = 1'b0;
        #1;
        n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL reset_im_req got=%0b want=0", im_req); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        n_cmp++; if (instr !== 32'h13) begin n_err++; $display("FAIL reset_instr got=%h want=00000013", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h want=0", instr_pc); end
    endtask

    task automatic test_stream();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++; if (im_req !== 1'b1 || im_addr !== 30'h0) begin n_err++; $display("FAIL first_issue req=%0b addr=%h want req=1 addr=0", im_req, im_addr); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_c0_valid got=%0b want=0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_c1_valid got=%0b want=0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0) begin n_err++; $display("FAIL stream_c2 v=%0b pc=%h i=%h want v=1 pc=0 i=0", out_valid, instr_pc, instr); end
        for (int k = 1; k <= 5; k++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr !== 32'(k)) begin n_err++; $display("FAIL stream_k%0d v=%0b pc=%h i=%h want pc=%h i=%h", k, out_valid, instr_pc, instr, 4 * k, k); end
        end
        exp_pc = 32'd20;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL stall_im_req got=%0b want=0", im_req); end
        n_cmp++; if (dut.u_fifo.count !== 3'd4) begin n_err++; $display("FAIL stall_count got=%0d want=4", dut.u_fifo.count); end
        n_cmp++; if (instr_pc !== exp_pc) begin n_err++; $display("FAIL stall_head got=%h want=%h", instr_pc, exp_pc); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || instr_pc !== exp_pc || instr !== (exp_pc >> 2)) begin n_err++; $display("FAIL release_%0d v=%0b pc=%h i=%h want pc=%h", i, out_valid, instr_pc, instr, exp_pc); end
            step();
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_full_pushpop();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (dut.u_fifo.count !== 3'd4) begin n_err++; $display("FAIL refill_count got=%0d want=4", dut.u_fifo.count); end
        for (int i = 0; i < 12; i++) begin
            out_ready = i[0];
            n_cmp++; if (out_valid !== 1'b1 || instr_pc !== exp_pc || instr !== (exp_pc >> 2)) begin n_err++; $display("FAIL full_order_%0d v=%0b pc=%h i=%h want pc=%h", i, out_valid, instr_pc, instr, exp_pc); end
            n_cmp++; if (dut.u_fifo.count > 3'd4) begin n_err++; $display("FAIL full_bound_%0d count=%0d want<=4", i, dut.u_fifo.count); end
            step();
            if (i[0]) exp_pc += 32'd4;
        end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0;
        do_redirect(32'h100);
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (dut.u_fifo.count !== 3'd3 || dut.inflight !== 1'b1) begin n_err++; $display("FAIL redir_setup count=%0d infl=%0b want 3/1", dut.u_fifo.count, dut.inflight); end
        out_ready = 1'b1;
        do_redirect(32'h40);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_c0_valid got=%0b want=0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_c1_valid got=%0b want=0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h10) begin n_err++; $display("FAIL redir_target v=%0b pc=%h i=%h want pc=40 i=10", out_valid, instr_pc, instr); end
        step();
        n_cmp++; if (instr_pc !== 32'h44) begin n_err++; $display("FAIL redir_next got=%h want=44", instr_pc); end
        step();
        n_cmp++; if (instr_pc !== 32'h48) begin n_err++; $display("FAIL redir_next2 got=%h want=48", instr_pc); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        do_redirect(32'h200);
        do_redirect(32'h300);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_c0_valid got=%0b want=0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_c1_valid got=%0b want=0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || instr_pc !== 32'h300 || instr !== 32'hC0) begin n_err++; $display("FAIL b2b_target v=%0b pc=%h i=%h want pc=300 i=c0", out_valid, instr_pc, instr); end
        step();
        n_cmp++; if (instr_pc !== 32'h304) begin n_err++; $display("FAIL b2b_next got=%h want=304", instr_pc); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        do_redirect(32'hFFFF_FFFC);
        step(); step();
        n_cmp++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'h3FFF_FFFF) begin n_err++; $display("FAIL wrap_top pc=%h i=%h want pc=fffffffc i=3fffffff", instr_pc, instr); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0) begin n_err++; $display("FAIL wrap_zero v=%0b pc=%h i=%h want pc=0 i=0", out_valid, instr_pc, instr); end
        do_redirect(32'h43);
        step(); step();
        n_cmp++; if (instr_pc !== 32'h40 || instr !== 32'h10) begin n_err++; $display("FAIL unaligned pc=%h i=%h want pc=40 i=10", instr_pc, instr); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        #1;
        n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL rstmid_req_comb got=%0b want=0", im_req); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || instr !== 32'h13 || instr_pc !== 32'h0 || im_req !== 1'b0) begin n_err++; $display("FAIL rstmid_outputs v=%0b i=%h pc=%h req=%0b want 0/13/0/0", out_valid, instr, instr_pc, im_req); end
        rst = 1'b0; redirect = 1'b0;
        #1;
        n_cmp++; if (im_req !== 1'b1 || im_addr !== 30'h0) begin n_err++; $display("FAIL rstmid_restart req=%0b addr=%h want 1/0", im_req, im_addr); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_c1_valid got=%0b want=0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || instr_pc !== 32'h0) begin n_err++; $display("FAIL rstmid_first v=%0b pc=%h want 1/0", out_valid, instr_pc); end
        step();
        n_cmp++; if (instr_pc !== 32'h4 || instr !== 32'h1) begin n_err++; $display("FAIL rstmid_second pc=%h i=%h want 4/1", instr_pc, instr); end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_full_pushpop();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
